// File: rtl/bus_arbiter.sv
// bus_arbiter: central arbiter and slave-select sequencer for the serial bus.
// Grants one of N_MASTERS masters and decodes the serial slave-select prefix
// (LSB first) into a one-hot slave_sel. A master whose slave raises split_en
// is parked, and it is resumed with priority once that slave releases the split.
// Build option: define ROUND_ROBIN_EN for round-robin arbitration of new
// requests. When it is undefined, arbitration is fixed priority with index 0 highest.
module bus_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 3,
    parameter int SEL_BITS  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_MASTERS-1:0]         breq,
    input  logic [N_MASTERS-1:0]         m_valid,
    input  logic [N_MASTERS-1:0]         m_addr,
    input  logic [N_SLAVES-1:0]          split_en,
    output logic [N_MASTERS-1:0]         bgrant,
    output logic [$clog2(N_MASTERS)-1:0] m_sel,
    output logic [N_SLAVES-1:0]          slave_sel,
    output logic [N_MASTERS-1:0]         split_pending,
    output logic                         sel_err
);
    localparam int MW = $clog2(N_MASTERS);
    localparam int CW = $clog2(SEL_BITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_SEL, S_BUSY} state_t;

    state_t               r_state;
    logic [N_MASTERS-1:0] r_bgrant;
    logic [MW-1:0]        r_m_sel;
    logic [N_SLAVES-1:0]  r_slave_sel;
    logic [N_SLAVES-1:0]  r_split_prev;
    logic [N_MASTERS-1:0] r_split_pending;
    logic                 r_sel_err;
    logic [SEL_BITS-1:0]  r_shift;
    logic [SEL_BITS-1:0]  r_cur_slv;
    logic [CW-1:0]        r_cnt;
    logic [SEL_BITS-1:0]  r_park [N_MASTERS];
`ifdef ROUND_ROBIN_EN
    logic [MW-1:0]        r_last;
`endif

    logic [N_MASTERS-1:0] w_res_ready;
    logic                 w_res_found;
    logic [MW-1:0]        w_res_idx;
    logic [SEL_BITS-1:0]  w_res_slv;
    logic [N_MASTERS-1:0] w_elig;
    logic                 w_new_found;
    logic [MW-1:0]        w_new_idx;
    logic                 w_cur_bit;
    logic [SEL_BITS:0]    w_shift_ext;
    logic [SEL_BITS-1:0]  w_s;
    logic                 w_s_parked;
    logic                 w_s_ok;
    logic                 w_last_bit;
    logic                 w_split_rise;

    assign bgrant        = r_bgrant;
    assign m_sel         = r_m_sel;
    assign slave_sel     = r_slave_sel;
    assign split_pending = r_split_pending;
    assign sel_err       = r_sel_err;

    function automatic logic [N_SLAVES-1:0] slave_onehot(input logic [SEL_BITS-1:0] idx);
        logic [N_SLAVES-1:0] oh;
        oh = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            oh[k] = (int'(idx) == k);
        end
        return oh;
    endfunction

    function automatic logic [N_MASTERS-1:0] master_onehot(input logic [MW-1:0] idx);
        return N_MASTERS'(1) << idx;
    endfunction

    // Parked masters whose slave has released the split are ready to resume; lowest index wins.
    always_comb begin
        w_res_ready = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            for (int k = 0; k < N_SLAVES; k++) begin
                if (r_split_pending[i] && (int'(r_park[i]) == k) && !split_en[k]) begin
                    w_res_ready[i] = 1'b1;
                end
            end
        end
        w_res_found = |w_res_ready;
        w_res_idx   = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (w_res_ready[i]) begin
                w_res_idx = MW'(i);
            end
        end
        w_res_slv = r_park[w_res_idx];
    end

`ifdef ROUND_ROBIN_EN
    // Round-robin pick among fresh requesters, starting after the last granted master.
    always_comb begin
        int j;
        w_elig      = breq & ~r_split_pending;
        w_new_found = 1'b0;
        w_new_idx   = '0;
        j           = 0;
        for (int k = N_MASTERS; k >= 1; k--) begin
            j = (int'(r_last) + k) % N_MASTERS;
            if (w_elig[j]) begin
                w_new_found = 1'b1;
                w_new_idx   = MW'(j);
            end
        end
    end
`else
    // Fixed-priority pick among fresh requesters, index 0 highest; parked masters are ignored.
    always_comb begin
        w_elig      = breq & ~r_split_pending;
        w_new_found = 1'b0;
        w_new_idx   = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_new_found = 1'b1;
                w_new_idx   = MW'(i);
            end
        end
    end
`endif

    // Prefix assembly and decode: the incoming bit enters at the MSB end, so the first bit ends at the LSB.
    always_comb begin
        w_cur_bit   = m_addr[r_m_sel];
        w_shift_ext = {w_cur_bit, r_shift};
        w_s         = w_shift_ext[SEL_BITS:1];
        w_last_bit  = (int'(r_cnt) == SEL_BITS - 1);
        w_s_parked  = 1'b0;
        for (int j = 0; j < N_MASTERS; j++) begin
            if (r_split_pending[j] && (r_park[j] == w_s)) begin
                w_s_parked = 1'b1;
            end
        end
        w_s_ok       = (int'(w_s) < N_SLAVES) && !w_s_parked;
        w_split_rise = |(split_en & ~r_split_prev & r_slave_sel);
    end

    // Arbitration / select / busy sequencer with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_bgrant        <= '0;
            r_m_sel         <= '0;
            r_slave_sel     <= '0;
            r_split_prev    <= '0;
            r_split_pending <= '0;
            r_sel_err       <= 1'b0;
            r_shift         <= '0;
            r_cur_slv       <= '0;
            r_cnt           <= '0;
            for (int i = 0; i < N_MASTERS; i++) begin
                r_park[i] <= '0;
            end
`ifdef ROUND_ROBIN_EN
            r_last          <= '0;
`endif
        end else begin
            r_sel_err    <= 1'b0;
            r_split_prev <= split_en;
            case (r_state)
                S_IDLE: begin
                    if (w_res_found) begin
                        // The parked record is consumed whether or not the master still wants the bus.
                        r_split_pending[w_res_idx] <= 1'b0;
                        if (breq[w_res_idx]) begin
                            r_bgrant    <= master_onehot(w_res_idx);
                            r_m_sel     <= w_res_idx;
                            r_cur_slv   <= w_res_slv;
                            r_slave_sel <= slave_onehot(w_res_slv);
`ifdef ROUND_ROBIN_EN
                            r_last      <= w_res_idx;
`endif
                            r_state     <= S_BUSY;
                        end
                    end else if (w_new_found) begin
                        r_bgrant <= master_onehot(w_new_idx);
                        r_m_sel  <= w_new_idx;
                        r_shift  <= '0;
                        r_cnt    <= '0;
`ifdef ROUND_ROBIN_EN
                        r_last   <= w_new_idx;
`endif
                        r_state  <= S_SEL;
                    end
                end
                S_SEL: begin
                    if (!breq[r_m_sel]) begin
                        r_bgrant <= '0;
                        r_state  <= S_IDLE;
                    end else if (m_valid[r_m_sel]) begin
                        if (w_last_bit) begin
                            r_cnt <= '0;
                            if (w_s_ok) begin
                                r_cur_slv   <= w_s;
                                r_slave_sel <= slave_onehot(w_s);
                                r_state     <= S_BUSY;
                            end else begin
                                r_sel_err   <= 1'b1;
                                r_bgrant    <= '0;
                                r_slave_sel <= '0;
                                r_state     <= S_IDLE;
                            end
                        end else begin
                            r_shift <= w_s;
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    // A split wins over a simultaneous release so the master stays parked.
                    if (w_split_rise) begin
                        r_split_pending[r_m_sel] <= 1'b1;
                        r_park[r_m_sel]          <= r_cur_slv;
                        r_bgrant                 <= '0;
                        r_slave_sel              <= '0;
                        r_state                  <= S_IDLE;
                    end else if (!breq[r_m_sel]) begin
                        r_bgrant    <= '0;
                        r_slave_sel <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_bgrant    <= '0;
                    r_slave_sel <= '0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios followed by random traffic, all checked
// cycle by cycle against a transaction-level reference model of the arbiter.
module tb_bus_arbiter;
    localparam int NM = 2;
    localparam int NS = 3;
    localparam int SB = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [NM-1:0] breq, m_valid, m_addr;
    logic [NS-1:0] split_en;
    logic [NM-1:0] bgrant;
    logic [0:0]    m_sel;
    logic [NS-1:0] slave_sel;
    logic [NM-1:0] split_pending;
    logic          sel_err;

    always #5 clk = ~clk;

    bus_arbiter #(.N_MASTERS(NM), .N_SLAVES(NS), .SEL_BITS(SB)) dut (
        .clk(clk), .reset(reset), .breq(breq), .m_valid(m_valid), .m_addr(m_addr),
        .split_en(split_en), .bgrant(bgrant), .m_sel(m_sel), .slave_sel(slave_sel),
        .split_pending(split_pending), .sel_err(sel_err)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: owner (-1 none), phase 0 idle / 1 prefix / 2 data transfer.
    int            owner, phase, cur_slave, exp_msel;
    bit            exp_err;
    int            parked [NM];
    int            pq [$];
    logic [NS-1:0] prev_split;
`ifdef ROUND_ROBIN_EN
    int            last_g;
`endif

    function automatic bit sbit(input logic [NS-1:0] v, input int idx);
        return ((v >> idx) & NS'(1)) != '0;
    endfunction

    function automatic bit mbit(input logic [NM-1:0] v, input int idx);
        return ((v >> idx) & NM'(1)) != '0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1; phase = 0; cur_slave = 0; exp_msel = 0; exp_err = 1'b0;
        for (int i = 0; i < NM; i++) parked[i] = -1;
        pq.delete();
        prev_split = '0;
`ifdef ROUND_ROBIN_EN
        last_g = 0;
`endif
    endtask

    function automatic bit slave_is_parked(input int s);
        for (int j = 0; j < NM; j++) if (parked[j] == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int pick_new();
        int w;
        w = -1;
`ifdef ROUND_ROBIN_EN
        for (int k = 1; k <= NM; k++) begin
            int j;
            j = (last_g + k) % NM;
            if (w < 0 && mbit(breq, j) && parked[j] < 0) w = j;
        end
`else
        for (int i = 0; i < NM; i++) if (w < 0 && mbit(breq, i) && parked[i] < 0) w = i;
`endif
        return w;
    endfunction

    task automatic grant_to(input int w);
        owner = w; exp_msel = w;
`ifdef ROUND_ROBIN_EN
        last_g = w;
`endif
    endtask

    task automatic model_step();
        int win, s;
        exp_err = 1'b0;
        case (phase)
            0: begin
                win = -1;
                for (int i = 0; i < NM; i++)
                    if (win < 0 && parked[i] >= 0 && !sbit(split_en, parked[i])) win = i;
                if (win >= 0) begin
                    s = parked[win];
                    parked[win] = -1;
                    if (mbit(breq, win)) begin
                        grant_to(win); cur_slave = s; phase = 2;
                    end
                end else begin
                    win = pick_new();
                    if (win >= 0) begin
                        grant_to(win); phase = 1; pq.delete();
                    end
                end
            end
            1: begin
                if (!mbit(breq, owner)) begin
                    owner = -1; phase = 0;
                end else if (mbit(m_valid, owner)) begin
                    pq.push_back(int'(mbit(m_addr, owner)));
                    if (pq.size() == SB) begin
                        s = 0;
                        for (int b = 0; b < SB; b++) s += pq[b] << b;
                        pq.delete();
                        if (s < NS && !slave_is_parked(s)) begin
                            cur_slave = s; phase = 2;
                        end else begin
                            exp_err = 1'b1; owner = -1; phase = 0;
                        end
                    end
                end
            end
            default: begin
                if (sbit(split_en, cur_slave) && !sbit(prev_split, cur_slave)) begin
                    parked[owner] = cur_slave; owner = -1; phase = 0;
                end else if (!mbit(breq, owner)) begin
                    owner = -1; phase = 0;
                end
            end
        endcase
        prev_split = split_en;
    endtask

    task automatic check_model();
        logic [NM-1:0] eg, ep;
        logic [NS-1:0] es;
        for (int i = 0; i < NM; i++) begin
            eg[i] = (owner == i);
            ep[i] = (parked[i] >= 0);
        end
        for (int k = 0; k < NS; k++) es[k] = (phase == 2 && cur_slave == k);
        check("mdl_bgrant", 32'(bgrant), 32'(eg));
        check("mdl_m_sel", 32'(m_sel), 32'(exp_msel));
        check("mdl_slave_sel", 32'(slave_sel), 32'(es));
        check("mdl_split_pending", 32'(split_pending), 32'(ep));
        check("mdl_sel_err", 32'(sel_err), 32'(exp_err));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (reset) model_reset();
        else model_step();
        check_model();
    endtask

    initial begin
        reset = 1'b1; breq = '0; m_valid = '0; m_addr = '0; split_en = '0;
        model_reset();
        tick(); tick();
        check("rst_bgrant", 32'(bgrant), 32'h0);
        check("rst_slave_sel", 32'(slave_sel), 32'h0);
        check("rst_split_pending", 32'(split_pending), 32'h0);
        reset = 1'b0;
        tick();

        // Single request, prefix s=2 sent as bits 0 then 1
        breq = 2'b01; tick();
        check("t1_grant", 32'(bgrant), 32'h1);
        m_valid = 2'b01; m_addr = 2'b00; tick();
        m_addr = 2'b01; tick();
        check("t1_slave_sel", 32'(slave_sel), 32'h4);
        m_valid = '0; m_addr = '0; tick();
        breq = '0; tick();
        check("t1_rel_bgrant", 32'(bgrant), 32'h0);
        check("t1_rel_slave_sel", 32'(slave_sel), 32'h0);

        // Simultaneous requests
        breq = 2'b11; tick();
`ifndef ROUND_ROBIN_EN
        check("t2_prio_grant", 32'(bgrant), 32'h1);
`endif
        m_valid = 2'b11; m_addr = 2'b00; tick(); tick();
        m_valid = '0; breq = 2'b10; tick();
        check("t2_rel", 32'(bgrant), 32'h0);
        tick();
`ifndef ROUND_ROBIN_EN
        check("t2_second_grant", 32'(bgrant), 32'h2);
`endif
        breq = '0; tick();
        check("t2_sel_drop_grant", 32'(bgrant), 32'h0);
        check("t2_sel_drop_err", 32'(sel_err), 32'h0);

        // Split and resume
        breq = 2'b01; tick();
        m_valid = 2'b01; m_addr = 2'b01; tick();
        m_addr = 2'b00; tick();
        check("t3_m0_slave1", 32'(slave_sel), 32'h2);
        m_valid = '0; breq = 2'b11; tick();
        split_en = 3'b010; tick();
        check("t3_parked", 32'(split_pending), 32'h1);
        check("t3_parked_grant", 32'(bgrant), 32'h0);
        tick();
        check("t3_m1_grant", 32'(bgrant), 32'h2);
        m_valid = 2'b10; m_addr = 2'b00; tick(); tick();
        check("t3_m1_slave0", 32'(slave_sel), 32'h1);
        m_valid = '0; split_en = '0; tick();
        check("t3_no_preempt", 32'(bgrant), 32'h2);
        tick();
        breq = 2'b01; tick();
        check("t3_m1_rel", 32'(bgrant), 32'h0);
        tick();
        check("t3_resume_grant", 32'(bgrant), 32'h1);
        check("t3_resume_slave", 32'(slave_sel), 32'h2);
        check("t3_resume_clear", 32'(split_pending), 32'h0);
        breq = '0; tick();

        // Access to a parked slave, then resume with breq low
        breq = 2'b01; tick();
        m_valid = 2'b01; m_addr = 2'b01; tick();
        m_addr = 2'b00; tick();
        m_valid = '0; m_addr = '0; split_en = 3'b010; tick();
        breq = 2'b11; tick();
        check("t4_m1_grant", 32'(bgrant), 32'h2);
        m_valid = 2'b10; m_addr = 2'b10; tick();
        m_addr = 2'b00; tick();
        check("t4_sel_err", 32'(sel_err), 32'h1);
        check("t4_err_grant", 32'(bgrant), 32'h0);
        breq = 2'b01; m_valid = '0; tick();
        check("t4_err_pulse_end", 32'(sel_err), 32'h0);
        check("t4_still_parked", 32'(split_pending), 32'h1);
        breq = '0; split_en = '0; tick();
        check("t4_discard", 32'(split_pending), 32'h0);
        check("t4_discard_grant", 32'(bgrant), 32'h0);

        // Out-of-range prefix s=3
        breq = 2'b01; tick();
        m_valid = 2'b01; m_addr = 2'b01; tick(); tick();
        check("t5_oor_err", 32'(sel_err), 32'h1);
        check("t5_oor_grant", 32'(bgrant), 32'h0);
        breq = '0; m_valid = '0; m_addr = '0; tick();
        check("t5_err_end", 32'(sel_err), 32'h0);

        // Asynchronous reset while busy with a parked master
        breq = 2'b01; tick();
        m_valid = 2'b01; m_addr = 2'b01; tick();
        m_addr = 2'b00; tick();
        m_valid = '0; split_en = 3'b010; tick();
        breq = 2'b11; tick();
        m_valid = 2'b10; m_addr = 2'b00; tick(); tick();
        check("t6_pre_slave", 32'(slave_sel), 32'h1);
        check("t6_pre_parked", 32'(split_pending), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("t6_async_bgrant", 32'(bgrant), 32'h0);
        check("t6_async_slave_sel", 32'(slave_sel), 32'h0);
        check("t6_async_split", 32'(split_pending), 32'h0);
        check("t6_async_m_sel", 32'(m_sel), 32'h0);
        model_reset();
        breq = '0; m_valid = '0; m_addr = '0; split_en = '0;
        tick();
        reset = 1'b0;
        tick();

        // Random traffic against the reference model
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NM; i++) if ($urandom_range(7) == 0) breq[i] = ~breq[i];
            m_valid = NM'($urandom);
            m_addr  = NM'($urandom);
            for (int k = 0; k < NS; k++) if ($urandom_range(15) == 0) split_en[k] = ~split_en[k];
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Central arbiter and slave-select sequencer for the serial bus.
- Shares the bus between N_MASTERS masters.
- Decodes the serial slave-select prefix sent by the granted master and drives one-hot slave_sel to the slave ports.
- Parks a master whose slave asserts split_en, lets other masters use the bus meanwhile, and re-grants the parked master with priority once that slave drops split_en.

Parameters:
N_MASTERS, 2, number of requesting masters
N_SLAVES, 3, number of slave ports
SEL_BITS, 2, serial slave-select prefix bits sent by the master before the 12-bit address

Ports:
clk  input  1  bus clock
reset  input  1  asynchronous active-high reset
breq  input  N_MASTERS  bus request per master; held high until the master's transaction completes
m_valid  input  N_MASTERS  master valid, qualifies m_addr bits
m_addr  input  N_MASTERS  serial address line per master; slave-select prefix sent first, LSB first
split_en  input  N_SLAVES  split request from each slave port
bgrant  output  N_MASTERS  one-hot grant
m_sel  output  $clog2(N_MASTERS)  index of granted master, drives bus muxes; holds last value when no grant
slave_sel  output  N_SLAVES  one-hot selected slave, zero when none
split_pending  output  N_MASTERS  master is parked on a split
sel_err  output  1  one-cycle pulse: decoded slave is out of range or parked-busy

Behaviour:
- Reset (async, any state): bgrant=0, m_sel=0, slave_sel=0, split_pending=0, sel_err=0, sel shift register=0, bit counter=0, state=IDLE. Reset mid-transaction drops grant immediately; parked records are lost.
- States:
  - IDLE
    - Eligible requesters are breq[i] & ~split_pending[i], plus any parked master whose slave has dropped split_en (resume-ready).
    - Winner selection: resume-ready masters first (lowest index), else fixed priority (index 0 highest).
    - Grant registered: bgrant/m_sel valid the cycle after breq is sampled (1-cycle latency).
    - New grant -> SEL. Resume grant -> BUSY with slave_sel restored from the parked record, no prefix re-sent.
  - SEL
    - Shift m_addr[m_sel] on cycles where m_valid[m_sel]=1; bits LSB first; counter counts to SEL_BITS.
    - Prefix decoded as value s:
      - s<N_SLAVES and slave s not parked: slave_sel[s]=1 next cycle -> BUSY.
      - Otherwise: sel_err pulses 1 cycle, grant dropped, slave_sel=0 -> IDLE. Master must retry.
    - breq dropping in SEL -> IDLE, no error.
  - BUSY
    - breq[m_sel]=0 -> bgrant=0, slave_sel=0 next cycle -> IDLE.
    - Rising edge of split_en[sel] (sampled 0 then 1):
      - split_pending[m_sel]=1; record slave index.
      - Drop bgrant and slave_sel next cycle -> IDLE.
- Priority and simultaneity:
  - Split has priority over breq drop in the same cycle; the master stays parked.
- Parked-master bookkeeping:
  - split_pending[i] clears when that master's resume grant is issued.
  - Parked master's breq is ignored until resume; if breq[i] is low at resume time, the record is discarded and no grant is issued.
  - A slave holding a parked record refuses other masters (sel_err path).
- At most one grant at any time; no preemption of BUSY.
- Latency: grant drops exactly one cycle after the release or split event.

Optional Feature:
ROUND_ROBIN_EN:
- Defined: non-resume arbitration is round-robin. The search starts at the index after the last granted master, wrapping at N_MASTERS. Resume-ready masters still win first.
- Undefined: fixed priority, index 0 highest.

Test Plan:
- Single request: breq=01, prefix s=2 (bits 0,1) with m_valid -> bgrant=01 one cycle after breq; slave_sel=100 after the 2nd prefix bit; breq drop -> bgrant=00, slave_sel=000 next cycle.
- Simultaneous breq=11 with fixed priority -> bgrant=01; master 1 is granted only after master 0 drops breq. With ROUND_ROBIN_EN, a second round grants 10 first.
- Split and resume: M0 on slave 1; split_en=010 rises -> split_pending=01, bgrant=00 next cycle; M1 granted and selects slave 0; split_en drops while M1 is BUSY -> M0 is not granted until M1 releases, then bgrant=01 with slave_sel=010 and no SEL phase.
- Parked slave access: while slave 1 is parked by M0, M1 sends prefix 1 -> sel_err one-cycle pulse, bgrant=00.
- Out-of-range prefix s=3 with N_SLAVES=3 -> sel_err pulse, return to IDLE.
- Reset asserted in BUSY -> bgrant, slave_sel, and split_pending all 0 in the same cycle, without waiting for a clock edge.
